alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Function : Round-robin arbiter sharing one registered ALU between two
//            requesters, with one operation in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [3:0]            req0_op,
    input  logic [3:0]            req1_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_z,
    input  logic                  alu_ovf,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_z,
    output logic                  rsp_ovf,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_CAPT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_owner;
    logic                  r_last_grant;

    logic                  w_grant;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [3:0]            w_op;

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        w_grant = 1'b0;
        case (req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~r_last_grant;
            default: w_grant = 1'b0;
        endcase
        w_accept  = (r_state == S_IDLE) && (req_valid != 2'b00);
        req_ready = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
        w_a       = w_grant ? req1_a  : req0_a;
        w_b       = w_grant ? req1_b  : req0_b;
        w_op      = w_grant ? req1_op : req0_op;
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_ctrl     <= 4'd0;
            rsp_valid    <= 2'b00;
            rsp_z        <= '0;
            rsp_ovf      <= 1'b0;
            rsp_err      <= 1'b0;
            op_count     <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        alu_a    <= w_a;
                        alu_b    <= w_b;
                        alu_ctrl <= w_op;
                        r_owner  <= w_grant;
                        rsp_err  <= (w_op == 4'd0) || (w_op > 4'd7);
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    rsp_z     <= alu_z;
                    // Illegal opcodes never report overflow, whatever the ALU says.
                    rsp_ovf   <= alu_ovf & ~rsp_err;
                    rsp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready[r_owner]) begin
                        rsp_valid    <= 2'b00;
                        r_last_grant <= r_owner;
                        op_count     <= op_count + 16'd1;
                        alu_ctrl     <= 4'd0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Function : Directed and randomized checks of alu_arbiter against a
//            transaction-level reference model with an emulated registered ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]    req0_op, req1_op;
    logic [DW-1:0] alu_a, alu_b;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_z;
    logic          alu_ovf;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [DW-1:0] rsp_z;
    logic          rsp_ovf, rsp_err, busy;
    logic [15:0]   op_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference-model state
    logic        m_last = 1'b1;
    logic [15:0] m_cnt  = 16'd0;

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_z(alu_z), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // {overflow, result}; an unknown opcode yields 0 but raises overflow so
    // the arbiter's masking is exercised.
    function automatic logic [DW:0] ref_alu(input logic [3:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            4'd1:    return {1'b0, a} + {1'b0, b};
            4'd2:    return {a < b, a - b};
            4'd3:    return {1'b0, a & b};
            4'd4:    return {1'b0, a | b};
            4'd5:    return {1'b0, ~(a ^ b)};
            4'd6:    return {a[DW-1], a << 1};
            4'd7:    return {1'b0, a >> 1};
            default: return {1'b1, {DW{1'b0}}};
        endcase
    endfunction

    always @(posedge clk) {alu_ovf, alu_z} <= ref_alu(alu_ctrl, alu_a, alu_b);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pick_val();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(DW-1){1'b0}}};
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: present request, check grant, latency, RESP hold and release.
    task automatic run_txn(input logic [1:0] v,
                           input logic [3:0] op0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                           input logic [3:0] op1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                           input int hold, input bit keep_valid);
        logic          g;
        logic [1:0]    own;
        logic [3:0]    eop;
        logic [DW-1:0] ea, eb;
        logic [DW:0]   res;
        logic          eerr;
        req_valid = v;
        req0_op = op0; req0_a = a0; req0_b = b0;
        req1_op = op1; req1_a = a1; req1_b = b1;
        g    = (v == 2'b11) ? ~m_last : v[1];
        own  = g ? 2'b10 : 2'b01;
        eop  = g ? op1 : op0;
        ea   = g ? a1 : a0;
        eb   = g ? b1 : b0;
        eerr = (eop < 4'd1) || (eop > 4'd7);
        res  = ref_alu(eop, ea, eb);
        #1;
        chk("idle_req_ready", {62'd0, req_ready}, {62'd0, own});
        chk("idle_busy", {63'd0, busy}, 64'd0);
        tick();
        if (!keep_valid) req_valid = 2'b00;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        req0_op = 4'($urandom_range(0, 15)); req1_op = 4'($urandom_range(0, 15));
        chk("exec_busy", {63'd0, busy}, 64'd1);
        chk("exec_req_ready", {62'd0, req_ready}, 64'd0);
        chk("alu_ctrl", {60'd0, alu_ctrl}, {60'd0, eop});
        chk("alu_a", {32'd0, alu_a}, {32'd0, ea});
        chk("alu_b", {32'd0, alu_b}, {32'd0, eb});
        tick();
        chk("capt_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        tick();
        chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, own});
        chk("rsp_z", {32'd0, rsp_z}, {32'd0, (eerr ? {DW{1'b0}} : res[DW-1:0])});
        chk("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, (eerr ? 1'b0 : res[DW])});
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, eerr});
        for (int i = 0; i < hold; i++) begin
            rsp_ready = ($urandom_range(0, 1) == 1) ? ~own : 2'b00;
            tick();
            chk("hold_rsp_valid", {62'd0, rsp_valid}, {62'd0, own});
            chk("hold_rsp_z", {32'd0, rsp_z}, {32'd0, (eerr ? {DW{1'b0}} : res[DW-1:0])});
            chk("hold_req_ready", {62'd0, req_ready}, 64'd0);
            chk("hold_busy", {63'd0, busy}, 64'd1);
        end
        rsp_ready = own;
        tick();
        rsp_ready = 2'b00;
        m_cnt  = m_cnt + 16'd1;
        m_last = g;
        chk("done_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("done_busy", {63'd0, busy}, 64'd0);
        chk("op_count", {48'd0, op_count}, {48'd0, m_cnt});
        chk("idle_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_z", {32'd0, rsp_z}, 64'd0);
        chk("rst_rsp_ovf", {63'd0, rsp_ovf}, 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
        chk("rst_alu_b", {32'd0, alu_b}, 64'd0);
        chk("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_op_count", {48'd0, op_count}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_op = 4'd0; req1_op = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic ADD on each requester, including carry-out
        run_txn(2'b01, 4'd1, 32'd5, 32'd7, 4'd0, '0, '0, 0, 1'b0);
        run_txn(2'b10, 4'd0, '0, '0, 4'd1, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);

        // Both requesting continuously: grants alternate
        for (int k = 0; k < 4; k++)
            run_txn(2'b11, 4'd2, 32'd9, 32'd4, 4'd5, 32'd0, 32'd0, 0, 1'b1);
        req_valid = 2'b00;

        // Illegal opcode, then a long stall in RESP
        run_txn(2'b01, 4'd9, 32'h1234, 32'h5678, 4'd0, '0, '0, 0, 1'b0);
        run_txn(2'b10, 4'd0, '0, '0, 4'd4, 32'hF0F0_0000, 32'h0000_0F0F, 10, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 40; k++)
            run_txn(2'($urandom_range(1, 3)),
                    4'($urandom_range(0, 9)), pick_val(), pick_val(),
                    4'($urandom_range(0, 9)), pick_val(), pick_val(),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        req_valid = 2'b00;
        tick();

        // Reset during EXEC aborts the operation
        req_valid = 2'b01; req0_op = 4'd1; req0_a = 32'd3; req0_b = 32'd4;
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt  = 16'd0;
        m_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        end
        chk("post_rst_op_count", {48'd0, op_count}, 64'd0);

        // First tie after reset goes to requester 0
        run_txn(2'b11, 4'd6, 32'h8000_0001, '0, 4'd7, 32'd10, '0, 1, 1'b1);
        run_txn(2'b11, 4'd3, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd7, 32'd10, '0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
